// File: rtl/ac_err_sweep.sv
// ac_err_sweep: exhaustive accuracy sweep for 8x8 approximate multipliers.
// Drives all 65536 operand pairs, one per cycle, into an external multiplier.
// Compares each returned product with the exact a*b.
// Accumulates the error count, the sum of absolute errors and the worst-case error.
// Build option: define ERR_BIAS_EN to add the signed bias accumulator (sum_bias).
// When ERR_BIAS_EN is not defined, sum_bias is tied to zero.
module ac_err_sweep #(
  parameter int MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_prod,
  output logic        busy,
  output logic        done,
  output logic [16:0] err_cnt,
  output logic [31:0] sum_ed,
  output logic [15:0] max_ed,
  output logic [32:0] sum_bias
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // DRAIN lasts MUL_LAT cycles; with MUL_LAT=0 it is never entered.
  localparam int          PW         = (MUL_LAT > 0) ? MUL_LAT : 1;
  localparam logic [15:0] DRAIN_LAST = 16'(PW - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] cnt_reg;     // index of the pair currently on mul_a/mul_b
  logic [15:0] drain_reg;   // cycles spent in DRAIN so far
  logic        start_ok;    // start accepted at the coming edge

  // Tag entering the pipeline: is a pair presented, and what is its exact product
  logic        in_valid;
  logic [15:0] in_exact;
  // Tag aligned with the product now arriving on mul_prod
  logic        cmp_valid;
  logic [15:0] cmp_exact;
  logic [15:0] ed;

  assign in_valid = (state_reg == SWEEP);
  assign in_exact = {8'd0, mul_a} * {8'd0, mul_b};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SWEEP;
          start_ok   = 1'b1;
        end
      end
      SWEEP: begin
        busy = 1'b1;
        if (cnt_reg == 16'hFFFF) begin
          state_next = (MUL_LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_reg == DRAIN_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = SWEEP;
          start_ok   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand generation: the operand registers load the next pair so that pair k
  // is on the bus during the k-th SWEEP cycle; after 16'hFFFF they simply hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg   <= 16'd0;
      mul_a     <= 8'd0;
      mul_b     <= 8'd0;
      drain_reg <= 16'd0;
    end else if (start_ok) begin
      cnt_reg   <= 16'd0;
      mul_a     <= 8'd0;
      mul_b     <= 8'd0;
      drain_reg <= 16'd0;
    end else if (state_reg == SWEEP) begin
      cnt_reg   <= cnt_reg + 16'd1;
      drain_reg <= 16'd0;
      if (cnt_reg != 16'hFFFF) begin
        {mul_a, mul_b} <= cnt_reg + 16'd1;
      end
    end else if (state_reg == DRAIN) begin
      drain_reg <= drain_reg + 16'd1;
    end
  end

  generate
    if (MUL_LAT == 0) begin : g_comb_mul
      assign cmp_valid = in_valid;
      assign cmp_exact = in_exact;
    end else begin : g_tag_pipe
      logic        vld_pipe   [MUL_LAT];
      logic [15:0] exact_pipe [MUL_LAT];

      // Tag pipeline: delays valid + exact product by MUL_LAT cycles
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_LAT; i++) begin
            vld_pipe[i]   <= 1'b0;
            exact_pipe[i] <= 16'd0;
          end
        end else begin
          vld_pipe[0]   <= in_valid;
          exact_pipe[0] <= in_exact;
          for (int i = 1; i < MUL_LAT; i++) begin
            vld_pipe[i]   <= vld_pipe[i-1];
            exact_pipe[i] <= exact_pipe[i-1];
          end
        end
      end

      assign cmp_valid = vld_pipe[MUL_LAT-1];
      assign cmp_exact = exact_pipe[MUL_LAT-1];
    end
  endgenerate

  // Absolute error of the product arriving this cycle
  assign ed = (mul_prod >= cmp_exact) ? (mul_prod - cmp_exact) : (cmp_exact - mul_prod);

  // Error statistics; cleared on reset and on every accepted start
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      err_cnt <= 17'd0;
      sum_ed  <= 32'd0;
      max_ed  <= 16'd0;
    end else if (cmp_valid) begin
      if (ed != 16'd0) begin
        err_cnt <= err_cnt + 17'd1;
      end
      sum_ed <= sum_ed + {16'd0, ed};
      if (ed > max_ed) begin
        max_ed <= ed;
      end
    end
  end

`ifdef ERR_BIAS_EN
  logic [16:0] diff;
  logic [32:0] bias_reg;

  assign diff = {1'b0, mul_prod} - {1'b0, cmp_exact};

  // Signed bias accumulator, two's complement, same clearing as the other stats
  always_ff @(posedge clk) begin
    if (!rst_n || start_ok) begin
      bias_reg <= 33'd0;
    end else if (cmp_valid) begin
      bias_reg <= bias_reg + {{16{diff[16]}}, diff};
    end
  end

  assign sum_bias = bias_reg;
`else
  assign sum_bias = 33'd0;
`endif

endmodule

// File: tb/tb_ac_err_sweep.sv
// tb_ac_err_sweep: seven sweep engines run in parallel, each against its own
// multiplier model (exact, LSB-cleared, zero, 3-stage, mis-aligned 2-stage).
// Expected totals go into a scoreboard queue when a sweep is started; a monitor
// pops and compares them when the engine raises done.
module tb_ac_err_sweep;

  localparam int NI = 7;

`ifdef ERR_BIAS_EN
  localparam longint B2 = -64'sd16384;
  localparam longint B3 = -64'sd1065369600;
`else
  localparam longint B2 = 64'sd0;
  localparam longint B3 = 64'sd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n    [NI];
  logic        start    [NI];
  logic [7:0]  mul_a    [NI];
  logic [7:0]  mul_b    [NI];
  logic [15:0] mul_prod [NI];
  logic        busy     [NI];
  logic        done     [NI];
  logic [16:0] err_cnt  [NI];
  logic [31:0] sum_ed   [NI];
  logic [15:0] max_ed   [NI];
  logic [32:0] sum_bias [NI];

  always #5 clk = ~clk;

  // Instances: 0 exact, 1 LSB cleared, 2 zero, 3 LAT3 exact, 4 LAT3 vs 2-stage
  // model, 5 exact (start pulse + mid-sweep reset), 6 zero (start held in DONE)
  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = (gi == 3 || gi == 4) ? 3 : 0;
    logic [15:0] p0, s1, s2, s3;
    assign p0 = {8'd0, mul_a[gi]} * {8'd0, mul_b[gi]};
    always @(posedge clk) begin
      s1 <= p0;
      s2 <= s1;
      s3 <= s2;
    end
    if (gi == 1) begin : g_m
      assign mul_prod[gi] = p0 & 16'hFFFE;
    end else if (gi == 2 || gi == 6) begin : g_m
      assign mul_prod[gi] = 16'd0;
    end else if (gi == 3) begin : g_m
      assign mul_prod[gi] = s3;
    end else if (gi == 4) begin : g_m
      assign mul_prod[gi] = s2;
    end else begin : g_m
      assign mul_prod[gi] = p0;
    end

    ac_err_sweep #(.MUL_LAT(LAT)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[gi]),
      .start    (start[gi]),
      .mul_a    (mul_a[gi]),
      .mul_b    (mul_b[gi]),
      .mul_prod (mul_prod[gi]),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .err_cnt  (err_cnt[gi]),
      .sum_ed   (sum_ed[gi]),
      .max_ed   (max_ed[gi]),
      .sum_bias (sum_bias[gi])
    );
  end

  typedef struct {
    int     id;
    string  tag;
    bit     only_nz;
    longint err;
    longint sed;
    longint med;
    longint bias;
    longint bcyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_pass;
  int   busy_cnt  [NI];
  bit   done_prev [NI];

  task automatic check(input string nm, input longint act, input longint exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
  endtask

  function automatic void push(input int id, input string tag, input bit nz,
                               input longint e, input longint s, input longint m,
                               input longint b, input longint bc);
    exp_t x;
    x.id = id; x.tag = tag; x.only_nz = nz;
    x.err = e; x.sed = s; x.med = m; x.bias = b; x.bcyc = bc;
    sb_q.push_back(x);
  endfunction

  task automatic score(input int i);
    exp_t x;
    int   k;
    k = -1;
    for (int j = 0; j < sb_q.size(); j++) begin
      if (sb_q[j].id == i && k < 0) k = j;
    end
    if (k < 0) begin
      n_chk++;
      $display("FAIL inst%0d unexpected_done: got done=1, expected no sweep pending", i);
      return;
    end
    x = sb_q[k];
    sb_q.delete(k);
    $display("sweep %s inst%0d: err_cnt=%0d sum_ed=%0d max_ed=%0d sum_bias=%0d busy_cycles=%0d",
             x.tag, i, err_cnt[i], sum_ed[i], max_ed[i], $signed(sum_bias[i]), busy_cnt[i]);
    if (x.only_nz) begin
      check({x.tag, " err_cnt_nonzero"}, longint'(err_cnt[i] != 17'd0), 1);
    end else begin
      check({x.tag, " err_cnt"},  longint'(err_cnt[i]), x.err);
      check({x.tag, " sum_ed"},   longint'(sum_ed[i]),  x.sed);
      check({x.tag, " max_ed"},   longint'(max_ed[i]),  x.med);
      check({x.tag, " sum_bias"}, longint'($signed(sum_bias[i])), x.bias);
    end
    check({x.tag, " busy_cycles"}, longint'(busy_cnt[i]), x.bcyc);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n[i]) begin
          busy_cnt[i]  = 0;
          done_prev[i] = 1'b0;
        end else begin
          if (busy[i]) busy_cnt[i]++;
          if (done[i] && !done_prev[i]) begin
            score(i);
            busy_cnt[i] = 0;
          end
          done_prev[i] = done[i];
        end
      end
    end
  endtask

  function automatic longint any_out(input int i);
    return longint'(|{busy[i], done[i], err_cnt[i], sum_ed[i], max_ed[i],
                      sum_bias[i], mul_a[i], mul_b[i]});
  endfunction

  initial begin
    int  w;
    bit  seen;
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i]     = 1'b0;
      start[i]     = 1'b0;
      busy_cnt[i]  = 0;
      done_prev[i] = 1'b0;
    end
    fork
      monitor();
    join_none

    // Reset state of every engine
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check($sformatf("inst%0d reset_outputs", i), any_out(i), 0);

    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    check("idle_busy", longint'(busy[0]), 0);

    // Start all engines together
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) start[i] = 1'b1;
    push(0, "T1_exact",  1'b0, 0,     0,          0,     0,  65536);
    push(1, "T2_lsb",    1'b0, 16384, 16384,      1,     B2, 65536);
    push(2, "T3_zero",   1'b0, 65025, 1065369600, 65025, B3, 65536);
    push(3, "T4_lat3",   1'b0, 0,     0,          0,     0,  65539);
    push(4, "T4_lat3_2st", 1'b1, 0,   0,          0,     0,  65539);
    push(6, "T6_zero",   1'b0, 65025, 1065369600, 65025, B3, 65536);
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) start[i] = 1'b0;

    // Sweep cycle sc presents pair sc
    for (int sc = 0; sc < 3004; sc++) begin
      @(negedge clk);
      if (sc == 0 || sc == 1 || sc == 101 || sc == 257 || sc == 3001) begin
        check($sformatf("pair_a@%0d", sc), longint'(mul_a[0]), longint'(sc / 256));
        check($sformatf("pair_b@%0d", sc), longint'(mul_b[0]), longint'(sc % 256));
        check($sformatf("lat3_pair_b@%0d", sc), longint'(mul_b[3]), longint'(sc % 256));
        check($sformatf("busy@%0d", sc), longint'(busy[0]), 1);
      end
      if (sc == 512) begin
        check("zero_err@512",  longint'(err_cnt[2]), 255);
        check("zero_sum@512",  longint'(sum_ed[2]),  32640);
        check("zero_max@512",  longint'(max_ed[2]),  255);
        check("lsb_err@512",   longint'(err_cnt[1]), 128);
      end
      if (sc == 3001) begin
        check("rst_mid_outputs", any_out(5), 0);
      end
      @(posedge clk); #1;
      start[0] = (sc + 1 == 100);
      start[5] = (sc + 1 == 100) || (sc + 1 == 3002);
      rst_n[5] = !(sc + 1 == 3000);
      if (sc + 1 == 200) start[6] = 1'b1;
      if (sc + 1 == 3002) push(5, "T5_restart", 1'b0, 0, 0, 0, 0, 65536);
    end
    start[0] = 1'b0;
    start[5] = 1'b0;

    // start held high through DONE on engine 6
    w = 0;
    seen = 1'b0;
    while (w < 70000 && !seen) begin
      @(negedge clk);
      if (done[6]) seen = 1'b1;
      else w++;
    end
    check("t6_done_reached", longint'(seen), 1);
    if (seen) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_busy_again", longint'(busy[6]), 1);
      check("t6_done_drop",  longint'(done[6]), 0);
      check("t6_err_clear",  longint'(err_cnt[6]), 0);
      check("t6_sum_clear",  longint'(sum_ed[6]), 0);
      check("t6_max_clear",  longint'(max_ed[6]), 0);
      check("t1_done_holds", longint'(done[0]), 1);
      check("t2_err_holds",  longint'(err_cnt[1]), 16384);
    end
    start[6] = 1'b0;
    @(posedge clk); #1;
    rst_n[6] = 1'b0;
    @(posedge clk); #1;
    rst_n[6] = 1'b1;

    // Let the restarted engine finish
    w = 0;
    while (sb_q.size() != 0 && w < 10000) begin
      @(negedge clk);
      w++;
    end
    while (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL %s timeout: got no done, expected done within budget", sb_q[0].tag);
      void'(sb_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
